// File: rtl/cmac_tx_rr_arbiter.sv
// cmac_tx_rr_arbiter: packet-granular round-robin arbiter feeding the CMAC TX AXI4-Stream.
// Defining CMAC_TX_ARB_STATS_EN adds per-port packet counters (PKT_CNT) and a stall counter (STALL_CNT).
module cmac_tx_rr_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 512,
  parameter int ID_W    = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_PORTS-1:0]          S_TVALID,
  input  logic [N_PORTS*DATA_W-1:0]   S_TDATA,
  input  logic [N_PORTS*DATA_W/8-1:0] S_TSTRB,
  input  logic [N_PORTS-1:0]          S_TLAST,
  output logic [N_PORTS-1:0]          S_TREADY,
  output logic                        M_TVALID,
  output logic [DATA_W-1:0]           M_TDATA,
  output logic [DATA_W/8-1:0]         M_TSTRB,
  output logic                        M_TLAST,
  input  logic                        M_TREADY,
  output logic [ID_W-1:0]             GRANT_ID,
  output logic                        BUSY
`ifdef CMAC_TX_ARB_STATS_EN
  ,
  output logic [N_PORTS*32-1:0]       PKT_CNT,
  output logic [31:0]                 STALL_CNT
`endif
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state_r;
  logic [ID_W-1:0]     grant_r;
  logic [ID_W-1:0]     ptr_r;
  logic                m_tvalid_r;
  logic [DATA_W-1:0]   m_tdata_r;
  logic [STRB_W-1:0]   m_tstrb_r;
  logic                m_tlast_r;

  logic                load_en_s;
  logic                locked_s;
  logic                sel_tvalid_s;
  logic                sel_tlast_s;
  logic [DATA_W-1:0]   sel_tdata_s;
  logic [STRB_W-1:0]   sel_tstrb_s;
  logic [N_PORTS-1:0]  grant_oh_s;
  logic [N_PORTS-1:0]  s_tready_s;
  logic                accept_s;
  logic                last_acc_s;
  logic [N_PORTS-1:0]  req_other_s;
  logic [ID_W-1:0]     idle_grant_s;
  logic [ID_W-1:0]     next_grant_s;

  // First requester found searching ptr+1, ptr+2, ... (mod N_PORTS); the nearest hit is written last.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] idx_v;
    int              p_v;
    idx_v = ptr;
    for (int k = N_PORTS; k >= 1; k--) begin
      p_v = (int'(ptr) + k) % N_PORTS;
      if (req[p_v]) begin
        idx_v = ID_W'(p_v);
      end else begin
        idx_v = idx_v;
      end
    end
    return idx_v;
  endfunction

  // Granted-port mux, handshake and next-grant selection.
  always_comb begin
    load_en_s    = ~m_tvalid_r | M_TREADY;
    locked_s     = (state_r == ST_LOCKED);
    sel_tvalid_s = S_TVALID[grant_r];
    sel_tlast_s  = S_TLAST[grant_r];
    sel_tdata_s  = S_TDATA[int'(grant_r)*DATA_W +: DATA_W];
    sel_tstrb_s  = S_TSTRB[int'(grant_r)*STRB_W +: STRB_W];
    grant_oh_s   = {{(N_PORTS-1){1'b0}}, 1'b1} << grant_r;
    s_tready_s   = (locked_s & load_en_s) ? grant_oh_s : {N_PORTS{1'b0}};
    accept_s     = sel_tvalid_s & locked_s & load_en_s;
    last_acc_s   = accept_s & sel_tlast_s;
    // The granted port's valid belongs to the beat being consumed, so it cannot re-request yet.
    req_other_s  = S_TVALID & ~grant_oh_s;
    idle_grant_s = rr_pick(S_TVALID, ptr_r);
    next_grant_s = rr_pick(req_other_s, grant_r);
  end

  // Arbitration FSM: grant, pointer and lock state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      grant_r <= {ID_W{1'b0}};
      ptr_r   <= ID_W'(N_PORTS - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|S_TVALID) begin
            grant_r <= idle_grant_s;
            state_r <= ST_LOCKED;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (last_acc_s) begin
            ptr_r <= grant_r;
            if (|req_other_s) begin
              grant_r <= next_grant_s;
              state_r <= ST_LOCKED;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register stage; contents hold while the sink stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      m_tvalid_r <= 1'b0;
      m_tdata_r  <= {DATA_W{1'b0}};
      m_tstrb_r  <= {STRB_W{1'b0}};
      m_tlast_r  <= 1'b0;
    end else if (load_en_s) begin
      m_tvalid_r <= accept_s;
      if (accept_s) begin
        m_tdata_r <= sel_tdata_s;
        m_tstrb_r <= sel_tstrb_s;
        m_tlast_r <= sel_tlast_s;
      end
    end
  end

  assign S_TREADY = s_tready_s;
  assign M_TVALID = m_tvalid_r;
  assign M_TDATA  = m_tdata_r;
  assign M_TSTRB  = m_tstrb_r;
  assign M_TLAST  = m_tlast_r;
  assign GRANT_ID = grant_r;
  assign BUSY     = (state_r == ST_LOCKED);

`ifdef CMAC_TX_ARB_STATS_EN
  logic [N_PORTS*32-1:0] pkt_cnt_r;
  logic [31:0]           stall_cnt_r;

  // Per-port completed-packet and sink back-pressure counters; both wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pkt_cnt_r   <= {(N_PORTS*32){1'b0}};
      stall_cnt_r <= 32'd0;
    end else begin
      if (last_acc_s) begin
        pkt_cnt_r[int'(grant_r)*32 +: 32] <= pkt_cnt_r[int'(grant_r)*32 +: 32] + 32'd1;
      end
      if (m_tvalid_r & ~M_TREADY) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign PKT_CNT   = pkt_cnt_r;
  assign STALL_CNT = stall_cnt_r;
`endif

endmodule
